// File: rtl/dma_sequencer_pkg.sv
// dma_sequencer_pkg: shared DMA defines (FSM state encodings and transfer type codes)
package dma_sequencer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [2:0] {
    DMA_NONE    = 3'd0,
    DMA_MEM2PER = 3'd1,
    DMA_PER2MEM = 3'd2
  } dma_type_e;
  function automatic logic dma_type_valid(input logic [2:0] t);
    return t == DMA_MEM2PER || t == DMA_PER2MEM;
  endfunction
endpackage

// File: rtl/dma_sequencer.sv
// dma_sequencer: single-channel word-copy DMA between local memory and peripheral bus
module dma_sequencer
  import dma_sequencer_pkg::*;
#(
  parameter int LOCAL_W  = 16,
  parameter int REMOTE_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          dma_type,
  input  logic [LOCAL_W-1:0]  cfg_local_addr,
  input  logic [REMOTE_W-1:0] cfg_remote_addr,
  input  logic [15:0]         cfg_count,
  output logic                mem_req,
  output logic                mem_we,
  output logic [LOCAL_W-1:0]  mem_addr,
  output logic [15:0]         mem_wdata,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_ack,
  output logic                per_req,
  output logic                per_we,
  output logic [REMOTE_W-1:0] per_addr,
  output logic [15:0]         per_wdata,
  input  logic [15:0]         per_rdata,
  input  logic                per_ack,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [15:0]         words_left
);
  logic [1:0]          state_q, state_d;
  logic                m2p_q, m2p_d;
  logic [LOCAL_W-1:0]  laddr_q, laddr_d;
  logic [REMOTE_W-1:0] raddr_q, raddr_d;
  logic [15:0]         words_q, words_d;
  logic [15:0]         hold_q, hold_d;
  logic                pend_q, pend_d;
  logic                aborted_q, aborted_d;
  logic                accept, ack, stop;

  // req is a pure function of state, so reset drops it without waiting for a clock
  assign accept     = state_q == ST_IDLE && start && dma_type_valid(dma_type);
  assign ack        = state_q == ST_RD ? (m2p_q ? mem_ack : per_ack) :
                      state_q == ST_WR ? (m2p_q ? per_ack : mem_ack) : 1'b0;
  assign stop       = abort || pend_q;
  assign mem_req    = (state_q == ST_RD && m2p_q) || (state_q == ST_WR && !m2p_q);
  assign mem_we     = state_q == ST_WR && !m2p_q;
  assign per_req    = (state_q == ST_RD && !m2p_q) || (state_q == ST_WR && m2p_q);
  assign per_we     = state_q == ST_WR && m2p_q;
  assign mem_addr   = laddr_q;
  assign per_addr   = raddr_q;
  assign mem_wdata  = hold_q;
  assign per_wdata  = hold_q;
  assign busy       = state_q != ST_IDLE;
  assign done       = state_q == ST_DONE;
  assign aborted    = aborted_q;
  assign words_left = words_q;

  // Next-state: an abort only lands on a completing handshake, otherwise it stays pending
  always_comb begin
    state_d   = state_q;
    m2p_d     = m2p_q;
    laddr_d   = laddr_q;
    raddr_d   = raddr_q;
    words_d   = words_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d   = cfg_count == 16'd0 ? ST_DONE : ST_RD;
        m2p_d     = dma_type == DMA_MEM2PER;
        laddr_d   = cfg_local_addr;
        raddr_d   = cfg_remote_addr;
        words_d   = cfg_count;
        pend_d    = 1'b0;
        aborted_d = 1'b0;
      end
      ST_RD: begin
        pend_d = stop && !ack;
        if (ack) begin
          hold_d    = m2p_q ? mem_rdata : per_rdata;
          state_d   = stop ? ST_DONE : ST_WR;
          aborted_d = stop;
        end
      end
      ST_WR: begin
        pend_d = stop && !ack;
        if (ack) begin
          laddr_d   = laddr_q + LOCAL_W'(2);
          raddr_d   = raddr_q + REMOTE_W'(2);
          words_d   = words_q - 16'd1;
          state_d   = (stop || words_q == 16'd1) ? ST_DONE : ST_RD;
          aborted_d = stop;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      m2p_q     <= 1'b0;
      laddr_q   <= '0;
      raddr_q   <= '0;
      words_q   <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m2p_q     <= m2p_d;
      laddr_q   <= laddr_d;
      raddr_q   <= raddr_d;
      words_q   <= words_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
    end
  end
endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: randomized and directed checks of dma_sequencer against a transaction-level model
module tb_dma_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [2:0]  dma_type = '0;
  logic [15:0] cfg_local_addr = '0, cfg_count = '0;
  logic [23:0] cfg_remote_addr = '0;
  logic        mem_req, mem_we, per_req, per_we, busy, done, aborted;
  logic [15:0] mem_addr, mem_wdata, per_wdata, words_left;
  logic [23:0] per_addr;
  logic [15:0] mem_rdata = '0, per_rdata = '0;
  logic        mem_ack = 1'b0, per_ack = 1'b0;

  dma_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dma_type(dma_type),
    .cfg_local_addr(cfg_local_addr), .cfg_remote_addr(cfg_remote_addr), .cfg_count(cfg_count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata), .per_ack(per_ack),
    .busy(busy), .done(done), .aborted(aborted), .words_left(words_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    bit          we;
    logic [15:0] data;
    int          cyc;
    int          held;
  } txn_t;

  txn_t        mlog[$], plog[$], m_first, p_first;
  int          cyc = 0, checks = 0, errors = 0, stab_err = 0, done_cnt = 0, done_cyc = 0;
  int          m_dly = 0, p_dly = 0, m_wait = -1, p_wait = -1, m_held = 0, p_held = 0;
  logic        done_ab = 1'b0;
  logic [15:0] done_wl = '0, seed = 16'h1234;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input int unsigned a);
    logic [31:0] h;
    h = a * 32'd40503 + 32'd17;
    return h[15:0] ^ h[31:16] ^ seed;
  endfunction

  function automatic logic [15:0] per_val(input int unsigned a);
    logic [31:0] h;
    h = (a ^ 32'h00C3C3) * 32'd2654435761;
    return h[31:16] ^ seed;
  endfunction

  // Memory/peripheral responders plus protocol monitor, all on the falling edge
  always @(negedge clk) begin
    if (mem_req && per_req) stab_err++;
    if ((mem_req || per_req) && !busy) stab_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_ab  = aborted;
      done_wl  = words_left;
    end
    if (!mem_req) begin
      mem_ack = 1'b0; m_wait = -1; m_held = 0;
    end else begin
      if (m_wait < 0) begin
        m_wait  = m_dly < 0 ? int'($urandom_range(0, 3)) : m_dly;
        m_first = '{addr: 32'(mem_addr), we: mem_we, data: mem_wdata, cyc: cyc, held: 0};
      end else if (32'(mem_addr) != m_first.addr || mem_we != m_first.we || (mem_we && mem_wdata !== m_first.data))
        stab_err++;
      m_held++;
      if (m_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_val(32'(mem_addr));
        mlog.push_back('{addr: 32'(mem_addr), we: mem_we, data: mem_wdata, cyc: cyc, held: m_held});
        m_wait = -1; m_held = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        m_wait--;
      end
    end
    if (!per_req) begin
      per_ack = 1'b0; p_wait = -1; p_held = 0;
    end else begin
      if (p_wait < 0) begin
        p_wait  = p_dly < 0 ? int'($urandom_range(0, 3)) : p_dly;
        p_first = '{addr: 32'(per_addr), we: per_we, data: per_wdata, cyc: cyc, held: 0};
      end else if (32'(per_addr) != p_first.addr || per_we != p_first.we || (per_we && per_wdata !== p_first.data))
        stab_err++;
      p_held++;
      if (p_wait == 0) begin
        per_ack   = 1'b1;
        per_rdata = per_val(32'(per_addr));
        plog.push_back('{addr: 32'(per_addr), we: per_we, data: per_wdata, cyc: cyc, held: p_held});
        p_wait = -1; p_held = 0;
      end else begin
        per_ack   = 1'b0;
        per_rdata = 16'($urandom);
        p_wait--;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  // Launches one transfer and waits (bounded) for its done pulse
  task automatic run_xfer(input logic [2:0] t, input logic [15:0] la, input logic [23:0] ra,
                          input logic [15:0] n, input int ab_off, input bit ab_start, input bit mid_start,
                          output int s, output int ab_cyc, output bit ok);
    mlog.delete(); plog.delete();
    done_cnt = 0; stab_err = 0; ab_cyc = -1; ok = 1'b0;
    dma_type = t; cfg_local_addr = la; cfg_remote_addr = ra; cfg_count = n;
    start = 1'b1; abort = ab_start; s = cyc;
    tick;
    start = 1'b0; abort = 1'b0;
    dma_type = 3'($urandom); cfg_local_addr = 16'($urandom);
    cfg_remote_addr = 24'($urandom); cfg_count = 16'($urandom);
    for (int i = 0; i < 400 && !ok; i++) begin
      if (i == ab_off) begin abort = 1'b1; ab_cyc = cyc; end
      if (mid_start && i == 1) begin start = 1'b1; dma_type = 3'd1; cfg_count = 16'd5; end
      tick;
      abort = 1'b0; start = 1'b0;
      if (done_cnt > 0) ok = 1'b1;
    end
    tick; tick;
  endtask

  // Counts log entries that differ from the expected copy sequence
  function automatic int log_errs(input bit m2p, input int unsigned la, input int unsigned ra,
                                  input int nr, input int nw);
    int e = 0;
    for (int i = 0; i < nr; i++) begin
      int unsigned sa = m2p ? (la + 2 * i) % 32'h10000 : (ra + 2 * i) % 32'h1000000;
      txn_t x = m2p ? mlog[i] : plog[i];
      if (x.addr != sa || x.we) e++;
    end
    for (int i = 0; i < nw; i++) begin
      int unsigned sa = m2p ? (la + 2 * i) % 32'h10000 : (ra + 2 * i) % 32'h1000000;
      int unsigned da = m2p ? (ra + 2 * i) % 32'h1000000 : (la + 2 * i) % 32'h10000;
      logic [15:0] dv = m2p ? mem_val(sa) : per_val(sa);
      txn_t x = m2p ? plog[i] : mlog[i];
      if (x.addr != da || !x.we || x.data !== dv) e++;
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    checks++;
    if ({mem_req, per_req, mem_we, per_we, busy, done, aborted} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/busy/done/aborted=%b expected 0000000",
               {mem_req, per_req, mem_we, per_we, busy, done, aborted});
    end
    checks++;
    if ({words_left, mem_addr, per_addr, mem_wdata} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: words_left=%h mem_addr=%h per_addr=%h wdata=%h expected all 0",
               words_left, mem_addr, per_addr, mem_wdata);
    end
    rst = 1'b1;
    tick; tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 0; seed = 16'h1234;
    run_xfer(3'd1, 16'h0100, 24'h001000, 16'd3, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || done_cyc - s != 7) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d expected 7", ok ? done_cyc - s : -1);
    end
    checks++;
    if (mlog.size() != 3 || plog.size() != 3) begin
      errors++;
      $display("FAIL basic_count: mem txns %0d per txns %0d expected 3 3", mlog.size(), plog.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (mlog[i].addr != 32'h0100 + 2 * i || mlog[i].we || plog[i].addr != 32'h001000 + 2 * i
            || !plog[i].we || plog[i].data !== mem_val(32'h0100 + 2 * i)) begin
          errors++;
          $display("FAIL basic_word%0d: mem %h we%b per %h we%b data %h expected mem %h we0 per %h we1 data %h",
                   i, mlog[i].addr, mlog[i].we, plog[i].addr, plog[i].we, plog[i].data,
                   32'h0100 + 2 * i, 32'h001000 + 2 * i, mem_val(32'h0100 + 2 * i));
        end
      end
    checks++;
    if (done_wl !== 16'd0 || done_ab !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: words_left=%0d aborted=%b pulses=%0d expected 0 0 1", done_wl, done_ab, done_cnt);
    end
  endtask

  task automatic test_slow_ack;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 3;
    run_xfer(3'd2, 16'h4000, 24'h0A0000, 16'd2, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || plog.size() != 2 || mlog.size() != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL slow_count: done=%b per %0d mem %0d pulses %0d expected 1 2 2 1",
               ok, plog.size(), mlog.size(), done_cnt);
    end else
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (plog[i].held != 4 || plog[i].we || mlog[i].addr != 32'h4000 + 2 * i
            || mlog[i].data !== per_val(32'h0A0000 + 2 * i)) begin
          errors++;
          $display("FAIL slow_word%0d: held %0d we%b mem %h data %h expected held 4 we0 mem %h data %h",
                   i, plog[i].held, plog[i].we, mlog[i].addr, mlog[i].data,
                   32'h4000 + 2 * i, per_val(32'h0A0000 + 2 * i));
        end
      end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL slow_stable: protocol violations %0d expected 0", stab_err);
    end
  endtask

  task automatic test_zero_count;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 0;
    run_xfer(3'd1, 16'h1234, 24'h123456, 16'd0, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || done_cyc != s + 1 || mlog.size() + plog.size() != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL zero_count: done offset %0d txns %0d viol %0d expected 1 0 0",
               done_cyc - s, mlog.size() + plog.size(), stab_err);
    end
  endtask

  task automatic test_abort_wr;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 2;
    run_xfer(3'd1, 16'h0200, 24'h003000, 16'd3, 1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || mlog.size() != 1 || plog.size() != 1 || done_cyc != s + 5) begin
      errors++;
      $display("FAIL abort_wr_flow: reads %0d writes %0d done offset %0d expected 1 1 5",
               mlog.size(), plog.size(), done_cyc - s);
    end
    checks++;
    if (done_ab !== 1'b1 || done_wl !== 16'd2) begin
      errors++;
      $display("FAIL abort_wr_status: aborted=%b words_left=%0d expected 1 2", done_ab, done_wl);
    end
    tick; tick; tick;
    checks++;
    if (aborted !== 1'b1 || words_left !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: aborted=%b words_left=%0d busy=%b expected 1 2 0", aborted, words_left, busy);
    end
    dma_type = 3'd2; cfg_count = 16'd1; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: aborted=%b busy=%b expected 0 1", aborted, busy);
    end
    for (int i = 0; i < 20 && busy; i++) tick;
  endtask

  task automatic test_wrap;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 1;
    run_xfer(3'd1, 16'hFFFE, 24'hFFFFFE, 16'd2, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || mlog.size() != 2 || plog.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: mem %0d per %0d expected 2 2", mlog.size(), plog.size());
    end else begin
      checks++;
      if (mlog[1].addr != 0 || plog[1].addr != 0 || plog[1].data !== mem_val(0)) begin
        errors++;
        $display("FAIL wrap_addr: mem %h per %h data %h expected 0 0 %h",
                 mlog[1].addr, plog[1].addr, plog[1].data, mem_val(0));
      end
    end
  endtask

  task automatic test_ignore;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 0;
    for (int t = 0; t < 8; t++) begin
      if (t == 1 || t == 2) continue;
      dma_type = 3'(t); cfg_count = 16'd4; start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || per_req !== 1'b0) begin
        errors++;
        $display("FAIL bad_type%0d: busy=%b mem_req=%b per_req=%b expected 0 0 0", t, busy, mem_req, per_req);
      end
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    run_xfer(3'd1, 16'h0010, 24'h000020, 16'd2, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || done_ab !== 1'b0 || plog.size() != 2) begin
      errors++;
      $display("FAIL idle_abort: aborted=%b writes=%0d expected 0 2", done_ab, plog.size());
    end
    run_xfer(3'd2, 16'h0030, 24'h000040, 16'd2, -1, 1'b1, 1'b0, s, ab, ok);
    checks++;
    if (!ok || done_ab !== 1'b0 || mlog.size() != 2 || plog.size() != 2) begin
      errors++;
      $display("FAIL start_abort: aborted=%b writes=%0d reads=%0d expected 0 2 2", done_ab, mlog.size(), plog.size());
    end
  endtask

  task automatic test_back_to_back;
    int s, ab; bit ok;
    m_dly = 0; p_dly = 0;
    run_xfer(3'd1, 16'h0200, 24'h000300, 16'd3, -1, 1'b0, 1'b1, s, ab, ok);
    checks++;
    if (!ok || plog.size() != 3 || done_wl !== 16'd0 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start: writes %0d words_left %0d pulses %0d expected 3 0 1", plog.size(), done_wl, done_cnt);
    end else begin
      checks++;
      if (plog[2].addr != 32'h0304) begin
        errors++;
        $display("FAIL busy_start_addr: last write %h expected 304", plog[2].addr);
      end
    end
    run_xfer(3'd2, 16'h0010, 24'h000020, 16'd1, -1, 1'b0, 1'b0, s, ab, ok);
    checks++;
    if (!ok || mlog.size() != 1 || plog.size() != 1) begin
      errors++;
      $display("FAIL b2b_count: mem %0d per %0d expected 1 1", mlog.size(), plog.size());
    end else begin
      checks++;
      if (mlog[0].addr != 32'h10 || !mlog[0].we || mlog[0].data !== per_val(32'h20)) begin
        errors++;
        $display("FAIL b2b_write: addr %h we %b data %h expected 10 1 %h", mlog[0].addr, mlog[0].we, mlog[0].data, per_val(32'h20));
      end
    end
  endtask

  task automatic test_reset_mid;
    m_dly = 5; p_dly = 0;
    mlog.delete(); plog.delete(); done_cnt = 0;
    dma_type = 3'd1; cfg_local_addr = 16'h0500; cfg_remote_addr = 24'h000600; cfg_count = 16'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: mem_req=%b expected 1", mem_req);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || per_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: mem_req=%b per_req=%b busy=%b expected 0 0 0", mem_req, per_req, busy);
    end
    tick; tick; tick;
    rst = 1'b1;
    tick; tick;
    checks++;
    if (done_cnt != 0 || mlog.size() + plog.size() != 0 || words_left !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_quiet: pulses %0d txns %0d words_left %0d expected 0 0 0",
               done_cnt, mlog.size() + plog.size(), words_left);
    end
  endtask

  task automatic test_random;
    int s, ab, aoff, nr, nw, lastc, late;
    bit ok, exp_ab, m2p, cnt_ok;
    logic [2:0] t;
    logic [15:0] la, n;
    logic [23:0] ra;
    for (int it = 0; it < 25; it++) begin
      t = 3'($urandom_range(1, 2)); m2p = t == 3'd1;
      la = 16'($urandom); ra = 24'($urandom); n = 16'($urandom_range(0, 6));
      m_dly = -1; p_dly = -1; seed = 16'($urandom);
      aoff = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * 32'(n) + 6)) : -1;
      run_xfer(t, la, ra, n, aoff, 1'b0, 1'b0, s, ab, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand%0d_timeout: done seen 0 expected 1", it);
        do_reset;
        continue;
      end
      exp_ab = ab >= 0 && n != 16'd0;
      nr = m2p ? mlog.size() : plog.size();
      nw = m2p ? plog.size() : mlog.size();
      lastc = -1; late = 0;
      foreach (mlog[i]) begin
        if (mlog[i].cyc > lastc) lastc = mlog[i].cyc;
        if (ab >= 0 && mlog[i].cyc >= ab) late++;
      end
      foreach (plog[i]) begin
        if (plog[i].cyc > lastc) lastc = plog[i].cyc;
        if (ab >= 0 && plog[i].cyc >= ab) late++;
      end
      cnt_ok = exp_ab ? (nw <= int'(n) && (nr == nw || nr == nw + 1) && late == 1) : (nr == int'(n) && nw == int'(n));
      checks++;
      if (!cnt_ok) begin
        errors++;
        $display("FAIL rand%0d_count: reads %0d writes %0d after-abort %0d n %0d abort %b", it, nr, nw, late, n, exp_ab);
      end
      checks++;
      if (log_errs(m2p, 32'(la), 32'(ra), nr, nw) != 0) begin
        errors++;
        $display("FAIL rand%0d_data: %0d wrong transactions expected 0", it, log_errs(m2p, 32'(la), 32'(ra), nr, nw));
      end
      checks++;
      if (done_cnt != 1 || done_ab !== exp_ab || done_wl !== 16'(int'(n) - nw)) begin
        errors++;
        $display("FAIL rand%0d_done: pulses %0d aborted %b words_left %0d expected 1 %b %0d",
                 it, done_cnt, done_ab, done_wl, exp_ab, int'(n) - nw);
      end
      checks++;
      if (done_cyc != (n == 16'd0 ? s + 1 : lastc + 1)) begin
        errors++;
        $display("FAIL rand%0d_timing: done at %0d expected %0d", it, done_cyc, n == 16'd0 ? s + 1 : lastc + 1);
      end
      checks++;
      if (stab_err != 0 || busy !== 1'b0 || aborted !== exp_ab) begin
        errors++;
        $display("FAIL rand%0d_idle: viol %0d busy %b aborted %b expected 0 0 %b", it, stab_err, busy, aborted, exp_ab);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slow_ack;
    test_zero_count;
    test_abort_wr;
    test_wrap;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/dma_sequencer.md
DMA_SEQUENCER -- requirements
Module: dma_sequencer

Interface
REQ-001 SHALL have parameter LOCAL_W, default 16: local memory address width.
REQ-002 SHALL have parameter REMOTE_W, default 24: peripheral bus address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  single-cycle transfer launch, sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  stop request, level-sampled.
REQ-007 SHALL have ports dma_type in 3, cfg_local_addr in LOCAL_W, cfg_remote_addr in REMOTE_W, cfg_count in 16 (words); all captured on accepted start.
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out LOCAL_W, mem_wdata out 16, mem_rdata in 16, mem_ack in 1.
REQ-009 SHALL have ports per_req out 1, per_we out 1, per_addr out REMOTE_W, per_wdata out 16, per_rdata in 16, per_ack in 1.
REQ-010 SHALL have ports busy out 1, done out 1 (pulse), aborted out 1 (valid with done), words_left out 16.

Function
REQ-011 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-012 dma_type 1 SHALL mean memory->peripheral (RD on mem port, WR on per port); type 2 SHALL mean peripheral->memory; types 0, 3-7 SHALL make start ignored.
REQ-013 Accepted start SHALL capture configuration and enter RD next cycle with source req asserted; cfg_count 0 SHALL go directly to DONE.
REQ-014 Handshake: req, we, addr, wdata SHALL stay stable while req high; transfer completes in the cycle req=1 and ack=1; req SHALL drop the following cycle.
REQ-015 Ack in the same cycle as req assertion SHALL be legal; minimum cost is 2 cycles per word (RD, WR).
REQ-016 RD completion SHALL latch source rdata into a 16-bit holding register and enter WR; WR SHALL drive that register as wdata with we=1.
REQ-017 WR completion SHALL increment both addresses by 2 and decrement words_left; words_left reaching 0 SHALL enter DONE, else RD.
REQ-018 Address increments SHALL wrap modulo 2^LOCAL_W and 2^REMOTE_W without flag.
REQ-019 RD on the source port SHALL drive we=0; the idle port SHALL hold req=0.
REQ-020 DONE SHALL last one cycle with done=1, then IDLE; done SHALL be 0 in all other states.
REQ-021 busy SHALL be 1 in RD, WR, DONE and 0 in IDLE; start while busy SHALL be ignored.
REQ-022 Abort SHALL be latched as pending; never cut a handshake: takes effect at next ack completion (or immediately if no req outstanding), then DONE with aborted=1.
REQ-023 aborted SHALL be 0 on normal completion and hold until next accepted start.
REQ-024 Abort in IDLE SHALL have no effect; abort and start in the same IDLE cycle SHALL give start priority and not latch abort.
REQ-025 words_left SHALL show remaining words, freezing on abort.

Reset
REQ-026 rst low SHALL asynchronously force IDLE; all req, we, done, busy, aborted to 0; addresses, words_left, holding register to 0.
REQ-027 Reset mid-transfer SHALL drop req immediately with no completion pulse.

Structure
REQ-028 State encodings and DMA type codes (NONE=0, MEM2PER=1, PER2MEM=2) SHALL live in the shared DMA defines file used by the DMA configuration registers.
REQ-029 Single FSM module; no sub-module required.

Verification
REQ-030 type 1, local 0x0100, remote 0x001000, count 3, acks immediate -> mem reads 0x0100/0x0102/0x0104, per writes 0x001000/2/4 with matching data, done at cycle 7.
REQ-031 type 2, count 2, per_ack delayed 3 cycles -> per_req held 4 cycles, addr stable, mem writes correct data, done once.
REQ-032 count 0, type 1 -> DONE the cycle after start, no req ever asserted.
REQ-033 abort during WR with ack pending 2 cycles -> write completes, DONE next, aborted=1, words_left frozen.
REQ-034 local 0xFFFE, remote 0xFFFFFE, count 2 -> second word at 0x0000/0x000000.
REQ-035 rst low during RD with req high -> req 0 asynchronously, busy 0, no done pulse.
